// File: rtl/counter_arb_pkg.sv
// Shared types, default sizes and the round-robin pick function for counter_arbiter.
package counter_arb_pkg;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_REQ       = 16;
  localparam int MAX_IDX_W     = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;
  typedef logic [MAX_IDX_W-1:0]     idx_t;
  typedef logic [MAX_REQ-1:0]       req_vec_t;

  // One-hot pick of the first set bit of valid, searching ptr, ptr+1, ... and wrapping at n.
  function automatic req_vec_t rr_pick(input req_vec_t valid, input idx_t ptr, input int n);
    req_vec_t grant;
    logic     found;
    int       idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && valid[idx[3:0]]) begin
        grant[idx[3:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/counter_arbiter_rr.sv
// rr_arbiter: round-robin pointer plus combinational one-hot grant and its encoded index.
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int  N_REQ = DEFAULT_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] eligible,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] ptr;
  req_vec_t         pick;

  // Stage p0: pick the first eligible requester starting at the pointer; nothing while in reset.
  always_comb begin
    pick      = rr_pick(req_vec_t'(eligible), idx_t'(ptr), N_REQ);
    grant     = RESET ? '0 : pick[N_REQ-1:0];
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
    grant_any = |grant;
  end

  // Pointer moves just past the requester that was granted; it stays put when nobody is.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: per-requester count bank sharing one incrementer under round-robin grant.
// Build option COUNTER_ARB_SATURATE_EN: counts hold at all-ones instead of wrapping.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int  N_REQ = DEFAULT_N_REQ,
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [N_REQ-1:0] clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_count,
  output logic [IDX_W-1:0] grant_id,
  output logic             grant_vld,
  output logic [N_REQ-1:0] ovf
);

  // Returns {overflow, next count}; overflow marks an increment taken at all-ones.
  function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] cur);
    logic [WIDTH:0] res;
`ifdef COUNTER_ARB_SATURATE_EN
    if (&cur) res = {1'b1, cur};
    else      res = {1'b0, cur + WIDTH'(1)};
`else
    res = {1'b0, cur} + (WIDTH+1)'(1);
`endif
    return res;
  endfunction

  logic [N_REQ-1:0] eligible_p0;
  logic [N_REQ-1:0] grant_p0;
  logic [IDX_W-1:0] gidx_p0;
  logic             accept_p0;
  logic [WIDTH-1:0] sel_cnt_p0;
  logic [WIDTH-1:0] next_cnt_p0;
  logic             carry_p0;

  logic [WIDTH-1:0] cnt_bank [N_REQ];

  logic             grant_vld_p1;
  logic [IDX_W-1:0] grant_id_p1;
  logic [N_REQ-1:0] ovf_p1;

  // A lane being cleared this cycle cannot also be incremented.
  always_comb begin
    eligible_p0 = req_valid & ~clr;
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .CLK       (CLK),
    .RESET     (RESET),
    .eligible  (eligible_p0),
    .grant     (grant_p0),
    .grant_idx (gidx_p0),
    .grant_any (accept_p0)
  );

  assign req_ready = grant_p0;

  // Stage p0: select the granted lane's count and run it through the single shared incrementer.
  always_comb begin
    sel_cnt_p0 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_p0 == IDX_W'(i)) sel_cnt_p0 = cnt_bank[i];
    end
    {carry_p0, next_cnt_p0} = count_step(sel_cnt_p0);
  end

  // Count bank: reset and clear win; otherwise only the granted lane takes the incremented value.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (RESET || clr[i]) begin
        cnt_bank[i] <= '0;
      end else if (accept_p0 && (gidx_p0 == IDX_W'(i))) begin
        cnt_bank[i] <= next_cnt_p0;
      end
    end
  end

  // Stage p1: grant status and overflow pulse, registered one cycle after the accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      grant_vld_p1 <= 1'b0;
      grant_id_p1  <= '0;
      ovf_p1       <= '0;
    end else begin
      grant_vld_p1 <= accept_p0;
      ovf_p1       <= (accept_p0 && carry_p0) ? grant_p0 : '0;
      if (accept_p0) grant_id_p1 <= gidx_p0;
    end
  end

  assign grant_vld = grant_vld_p1;
  assign grant_id  = grant_id_p1;
  assign ovf       = ovf_p1;

  // Readback mux over the registered counts.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rd_idx == IDX_W'(i)) rd_count = cnt_bank[i];
    end
  end

endmodule
